// File: rtl/urna_pkg.sv
// Shared constants and types for the result-reporting transmitter.
// Frame length depends on URNA_APURACAO_CHK_EN (checksum byte appended when defined).
package urna_pkg;

  // Ballot box estado encodings
  localparam logic [1:0] EST_OFF    = 2'd0;
  localparam logic [1:0] EST_OPEN   = 2'd1;
  localparam logic [1:0] EST_CLOSED = 2'd2;
  localparam logic [1:0] EST_AUDIT  = 2'd3;

  localparam logic [7:0] DEF_HEADER = 8'hA5;

  // Frame byte positions
  localparam logic [2:0] IDX_HDR    = 3'd0;
  localparam logic [2:0] IDX_C1     = 3'd1;
  localparam logic [2:0] IDX_C2     = 3'd2;
  localparam logic [2:0] IDX_NULL   = 3'd3;
  localparam logic [2:0] IDX_SUM_HI = 3'd4;
  localparam logic [2:0] IDX_SUM_LO = 3'd5;
  localparam logic [2:0] IDX_CHK    = 3'd6;

  localparam logic [2:0] FRAME_LEN_BASE = 3'd6;
  localparam logic [2:0] FRAME_LEN_CHK  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/urna_xor_acc.sv
// 8-bit XOR accumulator with synchronous clear and enable; builds the frame checksum.
module urna_xor_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  always_ff @(posedge clk) begin
    if (rst || clr) acc <= 8'h00;
    else if (en)    acc <= acc ^ din;
  end

endmodule

// File: rtl/urna_apuracao_tx.sv
// Snapshots ballot totals on voting close and streams them as a byte frame.
// Define URNA_APURACAO_CHK_EN to append an XOR checksum byte (7-byte frame).
module urna_apuracao_tx
  import urna_pkg::*;
#(
  parameter logic [7:0] HEADER    = DEF_HEADER,
  parameter logic [1:0] ST_CLOSED = EST_CLOSED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] estado,
  input  logic [7:0] TotalC1,
  input  logic [7:0] TotalC2,
  input  logic [7:0] TotalNull,
  input  logic       resend,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

`ifdef URNA_APURACAO_CHK_EN
  localparam logic [2:0] FRAME_LEN = FRAME_LEN_CHK;
`else
  localparam logic [2:0] FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [2:0] LAST_IDX = FRAME_LEN - 3'd1;

  state_t     state;
  logic [1:0] estado_q;
  logic       close_q, resend_q;
  logic [7:0] snap_c1, snap_c2, snap_null;
  logic [2:0] idx, idx_nx;
  logic [9:0] sum;
  logic [7:0] next_byte;
  logic       closed, close_evt, accept, start;

  assign closed    = (estado == ST_CLOSED);
  assign close_evt = closed && (estado_q != ST_CLOSED);
  assign accept    = (state == S_SEND) && tx_valid && tx_ready;
  // Close and resend are registered one cycle before the frame starts.
  assign start     = ((state == S_IDLE) && close_q) ||
                     ((state == S_DONE) && closed && resend_q);
  assign idx_nx    = idx + 3'd1;
  assign sum       = {2'b00, snap_c1} + {2'b00, snap_c2} + {2'b00, snap_null};

`ifdef URNA_APURACAO_CHK_EN
  logic [7:0] acc;

  urna_xor_acc u_chk (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (accept),
    .din (tx_data),
    .acc (acc)
  );
`endif

  // Byte loaded into tx_data when the current one is accepted.
  always_comb begin
    next_byte = 8'h00;
    case (idx_nx)
      IDX_C1:     next_byte = snap_c1;
      IDX_C2:     next_byte = snap_c2;
      IDX_NULL:   next_byte = snap_null;
      IDX_SUM_HI: next_byte = {6'b000000, sum[9:8]};
      IDX_SUM_LO: next_byte = sum[7:0];
`ifdef URNA_APURACAO_CHK_EN
      // acc covers bytes up to SUM_HI; fold in SUM_LO being accepted now
      IDX_CHK:    next_byte = acc ^ tx_data;
`endif
      default:    next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      estado_q  <= EST_OFF;
      close_q   <= 1'b0;
      resend_q  <= 1'b0;
      snap_c1   <= 8'h00;
      snap_c2   <= 8'h00;
      snap_null <= 8'h00;
      idx       <= IDX_HDR;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      estado_q <= estado;
      close_q  <= (state == S_IDLE) && close_evt;
      resend_q <= (state == S_DONE) && resend;

      if ((state == S_IDLE) && close_evt) begin
        snap_c1   <= TotalC1;
        snap_c2   <= TotalC2;
        snap_null <= TotalNull;
      end

      if (start) begin
        state    <= S_SEND;
        idx      <= IDX_HDR;
        tx_data  <= HEADER;
        tx_valid <= 1'b1;
        busy     <= 1'b1;
        done     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_SEND: begin
            if (accept) begin
              if (idx == LAST_IDX) begin
                state    <= S_DONE;
                tx_valid <= 1'b0;
                tx_data  <= 8'h00;
                busy     <= 1'b0;
                done     <= 1'b1;
              end else begin
                idx     <= idx_nx;
                tx_data <= next_byte;
              end
            end
          end
          S_DONE: begin
            if (!closed) begin
              state <= S_IDLE;
              done  <= 1'b0;
            end
          end
          default: begin
            state    <= S_IDLE;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_urna_apuracao_tx.sv
// Self-checking bench for urna_apuracao_tx: table vectors, corner sequences, random frames.
module tb_urna_apuracao_tx;

`ifdef URNA_APURACAO_CHK_EN
  localparam int FLEN = 7;
`else
  localparam int FLEN = 6;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] estado = 2'd0;
  logic [7:0] TotalC1 = 8'd0, TotalC2 = 8'd0, TotalNull = 8'd0;
  logic       resend = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy, done;

  urna_apuracao_tx dut (
    .clk(clk), .rst(rst), .estado(estado),
    .TotalC1(TotalC1), .TotalC2(TotalC2), .TotalNull(TotalNull),
    .resend(resend), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] c1, c2, nul, hi, lo, chk;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change only at negedge; record accepted bytes and stall stability.
  task automatic tick();
    logic acc, stl;
    logic [7:0] d;
    acc = tx_valid && tx_ready && !rst;
    stl = tx_valid && !tx_ready && !rst;
    d   = tx_data;
    @(posedge clk);
    @(negedge clk);
    if (acc) rx_q.push_back(d);
    if (stl) check("stall_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, d});
  endtask

  // Reference frame from the byte-level definition of the protocol.
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    int s;
    logic [7:0] x;
    s = int'(a) + int'(b) + int'(c);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(8'(s / 256));
    exp_q.push_back(8'(s % 256));
`ifdef URNA_APURACAO_CHK_EN
    x = 8'h00;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
`else
    x = 8'h00;
`endif
  endfunction

  task automatic compare_frame(input string name);
    check({name, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_b%0d", name, i), rx_q[i], exp_q[i]);
  endtask

  task automatic run_frame(input bit rnd, input int max, output int cyc);
    cyc = 0;
    while (!done && cyc < max) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) begin
        TotalC1   = 8'($urandom);
        TotalC2   = 8'($urandom);
        TotalNull = 8'($urandom);
      end
      tick();
      cyc++;
    end
    tx_ready = 1'b1;
    check("frame_done", done, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; estado = 2'd0; resend = 1'b0; tx_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic close_and_latency(input string name);
    rx_q.delete();
    estado = 2'd2;
    tick();
    check({name, "_lat_n"}, tx_valid, 0);
    tick();
    check({name, "_lat_n1"}, {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hA5});
    check({name, "_busy"}, busy, 1);
  endtask

  initial begin
    int cyc;
    logic [7:0] a, b, c;
    tbl[0] = '{8'd2,   8'd1,   8'd3,   8'h00, 8'h06, 8'hA3};
    tbl[1] = '{8'd255, 8'd255, 8'd255, 8'h02, 8'hFD, 8'hA5};
    tbl[2] = '{8'd0,   8'd0,   8'd0,   8'h00, 8'h00, 8'hA5};
    tbl[3] = '{8'd128, 8'd128, 8'd0,   8'h01, 8'h00, 8'hA4};
    tbl[4] = '{8'd100, 8'd200, 8'd50,  8'h01, 8'h5E, 8'h64};

    tick();
    check("rst_outputs", {20'd0, tx_valid, busy, done, tx_data}, 32'd0);
    do_reset();
    check("post_rst_idle", {20'd0, tx_valid, busy, done, tx_data}, 32'd0);

    // Table-driven frames, tx_ready held high
    foreach (tbl[k]) begin
      do_reset();
      TotalC1 = tbl[k].c1; TotalC2 = tbl[k].c2; TotalNull = tbl[k].nul;
      estado = 2'd1;
      tick();
      close_and_latency($sformatf("tbl%0d", k));
      run_frame(1'b0, 40, cyc);
      check($sformatf("tbl%0d_cycles", k), cyc, FLEN);
      exp_q = '{8'hA5, tbl[k].c1, tbl[k].c2, tbl[k].nul, tbl[k].hi, tbl[k].lo};
`ifdef URNA_APURACAO_CHK_EN
      exp_q.push_back(tbl[k].chk);
`endif
      compare_frame($sformatf("tbl%0d", k));
      check($sformatf("tbl%0d_idle_out", k), {30'd0, tx_valid, busy}, 0);
    end

    // Totals change mid-frame; resend reuses the snapshot
    do_reset();
    TotalC1 = 8'd2; TotalC2 = 8'd1; TotalNull = 8'd3;
    estado = 2'd1; tick();
    close_and_latency("snap");
    tick();
    TotalC1 = 8'd9; TotalC2 = 8'd9; TotalNull = 8'd9;
    resend = 1'b1; tick(); resend = 1'b0;
    run_frame(1'b0, 40, cyc);
    model(8'd2, 8'd1, 8'd3);
    compare_frame("snap1");
    rx_q.delete();
    resend = 1'b1; tick(); resend = 1'b0;
    check("resend_m", tx_valid, 0);
    tick();
    check("resend_m1", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hA5});
    run_frame(1'b0, 40, cyc);
    compare_frame("snap2");

    // Reset mid-frame, then a fresh close after reset
    do_reset();
    TotalC1 = 8'd7; TotalC2 = 8'd8; TotalNull = 8'd9;
    estado = 2'd1; tick();
    close_and_latency("rstmid");
    cyc = 0;
    while (rx_q.size() < 3 && cyc < 20) begin tick(); cyc++; end
    check("rstmid_reach_idx3", rx_q.size(), 3);
    rst = 1'b1; tick();
    check("rstmid_valid", {30'd0, tx_valid, busy}, 0);
    rst = 1'b0; rx_q.delete();
    run_frame(1'b0, 40, cyc);
    model(8'd7, 8'd8, 8'd9);
    compare_frame("rstmid_new");

    // estado closed straight out of reset: one frame only, re-close gives another
    rst = 1'b1; estado = 2'd2; TotalC1 = 8'd5; TotalC2 = 8'd6; TotalNull = 8'd7;
    tick(); tick();
    rst = 1'b0; rx_q.delete();
    run_frame(1'b0, 40, cyc);
    model(8'd5, 8'd6, 8'd7);
    compare_frame("held1");
    rx_q.delete();
    for (int i = 0; i < 8; i++) tick();
    check("held_no_repeat", rx_q.size(), 0);
    check("held_done", done, 1);
    estado = 2'd0; tick();
    check("held_to_idle", {30'd0, done, busy}, 0);
    estado = 2'd2; rx_q.delete(); tick();
    run_frame(1'b0, 40, cyc);
    compare_frame("held2");

    // estado leaves mid-frame: frame completes, then IDLE
    do_reset();
    TotalC1 = 8'd10; TotalC2 = 8'd20; TotalNull = 8'd30;
    estado = 2'd1; tick();
    close_and_latency("leave");
    tick(); tick();
    estado = 2'd0;
    run_frame(1'b0, 40, cyc);
    model(8'd10, 8'd20, 8'd30);
    compare_frame("leave");
    tick();
    check("leave_idle", done, 0);

    // Random totals, random backpressure, random resend
    do_reset();
    for (int f = 0; f < 15; f++) begin
      estado = 2'd0; tick();
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      if (f == 0) begin a = 8'd255; b = 8'd255; c = 8'd255; end
      TotalC1 = a; TotalC2 = b; TotalNull = c;
      estado = 2'd2; rx_q.delete(); tick();
      run_frame(1'b1, 300, cyc);
      model(a, b, c);
      compare_frame($sformatf("rnd%0d", f));
      if ($urandom_range(0, 1) == 1) begin
        rx_q.delete();
        resend = 1'b1; tick(); resend = 1'b0; tick();
        run_frame(1'b1, 300, cyc);
        compare_frame($sformatf("rnd%0d_rs", f));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
